// File: rtl/placar_pkg.sv
// Shared constants for the placar_n scoreboard: default parameters, button point
// values and the active-high 7-segment digit table (bit0=a .. bit6=g).
package placar_pkg;

  localparam int unsigned DefNPlayers   = 2;
  localparam int unsigned DefMaxScore   = 99;
  localparam int unsigned DefNDigits    = 2;
  localparam int unsigned DefRefreshDiv = 50000;

  localparam logic [1:0] PtsBtn0 = 2'd1;
  localparam logic [1:0] PtsBtn1 = 2'd2;
  localparam logic [1:0] PtsBtn2 = 2'd3;

  // Element d holds the pattern for decimal digit d.
  localparam logic [9:0][6:0] SegLut = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bin_bcd_n.sv
// Combinational binary-to-BCD converter (double-dabble) producing N_DIGITS
// nibbles, digit 0 in the least significant nibble.
module bin_bcd_n #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned N_DIGITS = 2
) (
  input  logic [WIDTH-1:0]      bin_i,
  output logic [4*N_DIGITS-1:0] bcd_o
);

  logic [4*N_DIGITS-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      for (int d = 0; d < int'(N_DIGITS); d++) begin
        if (acc[4*d +: 4] >= 4'd5) begin
          acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
      end
      acc = {acc[4*N_DIGITS-2:0], bin_i[i]};
    end
    bcd_o = acc;
  end

endmodule

// File: rtl/placar_n.sv
// Multi-player saturating scoreboard with synchronized point buttons, preset load
// and a time-multiplexed 7-segment display.
module placar_n
  import placar_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = DefNPlayers,
  parameter int unsigned MAX_SCORE   = DefMaxScore,
  parameter int unsigned N_DIGITS    = DefNDigits,
  parameter int unsigned REFRESH_DIV = DefRefreshDiv
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [2:0]                                        btn,
  input  logic                                              sinal,
  input  logic [(N_PLAYERS > 1 ? $clog2(N_PLAYERS) : 1)-1:0] sel,
  input  logic                                              load,
  input  logic [6:0]                                        chave,
  output logic [6:0]                                        saida,
  output logic [N_PLAYERS*N_DIGITS-1:0]                     sclk,
  output logic                                              alerta
);

  localparam int unsigned SelW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int unsigned SW   = (MAX_SCORE > 0) ? $clog2(MAX_SCORE + 1) : 1;
  localparam int unsigned AW   = ((SW > 2) ? SW : 2) + 1;
  localparam int unsigned NS   = N_PLAYERS * N_DIGITS;
  localparam int unsigned CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned KW   = (NS > 1) ? $clog2(NS) : 1;

  // Bit 3 is load, bits 2:0 are the point buttons.
  logic [3:0] raw;
  logic [3:0] meta_q, meta_d, sync_q, sync_d, prev_q, prev_d, pulse_q, pulse_d;
  logic [1:0] arm_q, arm_d;

  assign raw = {load, btn};

  // Edges are only trusted once prev_q holds a real post-reset sample, so a
  // button held through reset release never produces a pulse.
  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    prev_d  = sync_q;
    arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    pulse_d = (arm_q == 2'd3) ? (sync_q & ~prev_q) : 4'b0000;
  end

  logic [N_PLAYERS-1:0][SW-1:0] score_q, score_d;
  logic                         alerta_q, alerta_d;
  logic [SW-1:0]                cur, nv;
  logic [AW-1:0]                sum;
  logic [1:0]                   pts;
  logic                         sel_ok, do_op, clamp;

  always_comb begin
    score_d  = score_q;
    alerta_d = alerta_q;
    cur      = '0;
    nv       = '0;
    sum      = '0;
    pts      = 2'd0;
    clamp    = 1'b0;
    do_op    = 1'b0;
    sel_ok   = (32'(sel) < N_PLAYERS);
    for (int p = 0; p < int'(N_PLAYERS); p++) begin
      if (sel == SelW'(p)) cur = score_q[p];
    end
    if (pulse_q[3]) begin
      do_op = 1'b1;
      clamp = (32'(chave) > MAX_SCORE);
      nv    = clamp ? SW'(MAX_SCORE) : SW'(chave);
    end else if (|pulse_q[2:0]) begin
      do_op = 1'b1;
      if (pulse_q[2])      pts = PtsBtn2;
      else if (pulse_q[1]) pts = PtsBtn1;
      else                 pts = PtsBtn0;
      if (!sinal) begin
        sum   = AW'(cur) + AW'(pts);
        clamp = (sum > AW'(MAX_SCORE));
        nv    = clamp ? SW'(MAX_SCORE) : SW'(sum);
      end else begin
        sum   = AW'(cur) - AW'(pts);
        clamp = (AW'(pts) > AW'(cur));
        nv    = clamp ? '0 : SW'(sum);
      end
    end
    if (do_op && sel_ok) begin
      alerta_d = pulse_q[3] ? clamp : (alerta_q | clamp);
      for (int p = 0; p < int'(N_PLAYERS); p++) begin
        if (sel == SelW'(p)) score_d[p] = nv;
      end
    end
  end

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         slot_q, slot_d;
  logic                  wrap;
  logic [SW-1:0]         disp_score;
  logic [4*N_DIGITS-1:0] disp_bcd;
  logic [3:0]            nib;
  logic [6:0]            saida_q, saida_d;
  logic [NS-1:0]         sclk_q, sclk_d;

  always_comb begin
    wrap   = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    slot_d = slot_q;
    if (wrap) slot_d = (slot_q == KW'(NS - 1)) ? '0 : slot_q + KW'(1);
  end

  always_comb begin
    disp_score = '0;
    for (int k = 0; k < int'(NS); k++) begin
      if (slot_q == KW'(k)) disp_score = score_q[k / int'(N_DIGITS)];
    end
  end

  bin_bcd_n #(
    .WIDTH    (SW),
    .N_DIGITS (N_DIGITS)
  ) u_bcd (
    .bin_i (disp_score),
    .bcd_o (disp_bcd)
  );

  always_comb begin
    nib    = 4'd0;
    sclk_d = '0;
    for (int k = 0; k < int'(NS); k++) begin
      if (slot_q == KW'(k)) begin
        nib       = disp_bcd[4*(k % int'(N_DIGITS)) +: 4];
        sclk_d[k] = 1'b1;
      end
    end
    saida_d = (nib < 4'd10) ? SegLut[nib] : 7'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      arm_q    <= '0;
      score_q  <= '0;
      alerta_q <= 1'b0;
      cnt_q    <= '0;
      slot_q   <= '0;
      saida_q  <= '0;
      sclk_q   <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
      arm_q    <= arm_d;
      score_q  <= score_d;
      alerta_q <= alerta_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      saida_q  <= saida_d;
      sclk_q   <= sclk_d;
    end
  end

  assign saida  = saida_q;
  assign sclk   = sclk_q;
  assign alerta = alerta_q;

endmodule

// File: tb/tb_placar_n.sv
// Self-checking bench for placar_n: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural scoreboard model.
module tb_placar_n;

  localparam int NP  = 2;
  localparam int MX  = 99;
  localparam int ND  = 2;
  localparam int DIV = 4;
  localparam int NS  = NP * ND;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn   = 3'b000;
  logic       sinal = 1'b0;
  logic [0:0] sel   = 1'b0;
  logic       load  = 1'b0;
  logic [6:0] chave = 7'd0;
  logic [6:0] saida;
  logic [3:0] sclk;
  logic       alerta;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  placar_n #(
    .N_PLAYERS   (NP),
    .MAX_SCORE   (MX),
    .N_DIGITS    (ND),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .sinal  (sinal),
    .sel    (sel),
    .load   (load),
    .chave  (chave),
    .saida  (saida),
    .sclk   (sclk),
    .alerta (alerta)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: n counts clock edges since reset release; a button or load
  // rise seen at edge n-3 (low at n-4) is applied at edge n.
  int         m_n = 0;
  int         m_score[NP];
  bit         m_alert = 1'b0;
  logic [3:0] m_hist[$];
  logic [6:0] e_saida = 7'h00;
  logic [3:0] e_sclk  = 4'h0;
  logic       e_alerta = 1'b0;

  task automatic model_step();
    int s, p, dg, v, pts;
    logic [3:0] rise;
    if (!rst_n) begin
      m_n = 0;
      for (int i = 0; i < NP; i++) m_score[i] = 0;
      m_alert = 1'b0;
      m_hist.delete();
      e_saida  = 7'h00;
      e_sclk   = 4'h0;
      e_alerta = 1'b0;
    end else begin
      s  = (m_n / DIV) % NS;
      p  = s / ND;
      dg = s % ND;
      e_sclk  = 4'(1 << s);
      e_saida = seg((m_score[p] / ((dg == 0) ? 1 : 10)) % 10);
      rise = (m_hist.size() >= 4) ? (m_hist[2] & ~m_hist[3]) : 4'b0000;
      pts  = rise[2] ? 3 : rise[1] ? 2 : rise[0] ? 1 : 0;
      if (int'(sel) < NP) begin
        if (rise[3]) begin
          v = int'(chave);
          m_alert = (v > MX);
          m_score[sel] = (v > MX) ? MX : v;
        end else if (pts != 0) begin
          v = sinal ? m_score[sel] - pts : m_score[sel] + pts;
          if (v > MX) begin
            v = MX;
            m_alert = 1'b1;
          end else if (v < 0) begin
            v = 0;
            m_alert = 1'b1;
          end
          m_score[sel] = v;
        end
      end
      e_alerta = m_alert;
      m_hist.push_front({load, btn});
      if (m_hist.size() > 5) void'(m_hist.pop_back());
      m_n++;
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) m_score[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_sclk", int'(sclk), int'(e_sclk));
      chk("model_saida", int'(saida), int'(e_saida));
      chk("model_alerta", int'(alerta), int'(e_alerta));
    end
  end

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] b);
    @(negedge clk);
    btn = b;
    idle(4);
    btn = 3'b000;
    idle(4);
  endtask

  task automatic do_load(input int p, input int v);
    @(negedge clk);
    sel   = 1'(p);
    chave = 7'(v);
    load  = 1'b1;
    idle(4);
    load = 1'b0;
    idle(4);
  endtask

  // Bounded wait for a display slot; an expired bound shows up as a failed compare.
  task automatic wait_slot(input logic [3:0] t);
    int k;
    k = 0;
    while (k < 64 && sclk !== t) begin
      @(negedge clk);
      k++;
    end
    chk("slot_reached", int'(sclk), int'(t));
  endtask

  task automatic chk_slot(input string name, input logic [3:0] t, input logic [6:0] pat);
    wait_slot(t);
    chk(name, int'(saida), int'(pat));
  endtask

  initial begin
    @(negedge clk);
    chk("rst_saida", int'(saida), 0);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_alerta", int'(alerta), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("idle_sclk", int'(sclk), 1 << (i / 4));
      chk("idle_saida", int'(saida), 'h3F);
    end

    sel = 1'b1;
    sinal = 1'b0;
    press(3'b100);
    press(3'b100);
    chk_slot("p1_units_6", 4'b0100, 7'h7D);
    chk_slot("p1_tens_0", 4'b1000, 7'h3F);
    chk("p1_alerta", int'(alerta), 0);

    do_load(0, 98);
    press(3'b100);
    chk("sat_alerta", int'(alerta), 1);
    chk_slot("sat_units", 4'b0001, 7'h6F);
    chk_slot("sat_tens", 4'b0010, 7'h6F);
    do_load(0, 10);
    chk("load_clears", int'(alerta), 0);
    chk_slot("ten_units", 4'b0001, 7'h3F);
    chk_slot("ten_tens", 4'b0010, 7'h06);

    do_load(0, 1);
    sinal = 1'b1;
    press(3'b010);
    chk("under_alerta", int'(alerta), 1);
    chk_slot("under_units", 4'b0001, 7'h3F);
    chk_slot("under_tens", 4'b0010, 7'h3F);
    do_load(0, 50);
    chk("fifty_alerta", int'(alerta), 0);
    press(3'b101);
    chk_slot("prio_units_7", 4'b0001, 7'h07);
    chk_slot("prio_tens_4", 4'b0010, 7'h66);
    chk("prio_alerta", int'(alerta), 0);
    chk_slot("p1_kept", 4'b0100, 7'h7D);

    sinal = 1'b0;
    do_load(0, 120);
    chk("big_load_alerta", int'(alerta), 1);
    chk_slot("big_units", 4'b0001, 7'h6F);
    chk_slot("big_tens", 4'b0010, 7'h6F);

    idle(1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_saida", int'(saida), 0);
    chk("async_sclk", int'(sclk), 0);
    chk("async_alerta", int'(alerta), 0);
    sel = 1'b0;
    btn = 3'b100;
    idle(2);
    rst_n = 1'b1;
    idle(20);
    chk_slot("held_units", 4'b0001, 7'h3F);
    chk_slot("held_tens", 4'b0010, 7'h3F);
    chk("held_alerta", int'(alerta), 0);
    btn = 3'b000;
    idle(4);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) btn = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) load = ~load;
      sel   = 1'($urandom_range(0, 1));
      sinal = 1'($urandom_range(0, 1));
      chave = 7'($urandom_range(0, 127));
    end
    btn = 3'b000;
    load = 1'b0;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
